// File: rtl/fan_speed_ramp_ctrl_pkg.sv
// Shared keypad codes and ramp FSM state type for the fan speed controller.
package fan_speed_ramp_ctrl_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_SLEEP = KEY_9;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/fan_speed_ramp_ctrl_pwm_gen.sv
// Free-running PWM generator; output is registered and high while pwm_cnt < duty.
module fan_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_out
);

  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/fan_speed_ramp_ctrl.sv
// Fan speed controller: keypad level select, ramped duty, PWM output and sleep timer.
module fan_speed_ramp_ctrl
  import fan_speed_ramp_ctrl_pkg::*;
#(
  parameter int LEVELS    = 4,
  parameter int PWM_W     = 8,
  parameter int RAMP_DIV  = 1024,
  parameter int SLEEP_CYC = 2**24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                key,
  input  logic                      key_valid,
  output logic [$clog2(LEVELS)-1:0] level,
  output logic [PWM_W-1:0]          duty,
  output logic                      pwm_out,
  output logic                      ramping,
  output logic                      sleep_arm
);

  localparam int LW  = $clog2(LEVELS);
  localparam int RCW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int SCW = $clog2(SLEEP_CYC);
  localparam logic [PWM_W-1:0] MAX_DUTY = '1;
  localparam logic [PWM_W-1:0] STEP     = PWM_W'((2**PWM_W - 1) / (LEVELS - 1));
  localparam logic [RCW-1:0]   RAMP_TC  = RCW'(RAMP_DIV - 1);
  localparam logic [SCW-1:0]   SLEEP_TC = SCW'(SLEEP_CYC - 1);

  logic [SCW-1:0]   sleep_cnt;
  logic [RCW-1:0]   ramp_cnt, ramp_cnt_nxt;
  logic [PWM_W-1:0] duty_nxt, tgt;
  ramp_state_t      state, state_nxt;

  // Timer expiry takes priority over any key strobe in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level     <= '0;
      sleep_arm <= 1'b0;
      sleep_cnt <= '0;
    end else if (sleep_arm && sleep_cnt == SLEEP_TC) begin
      level     <= '0;
      sleep_arm <= 1'b0;
      sleep_cnt <= '0;
    end else begin
      if (sleep_arm)
        sleep_cnt <= sleep_cnt + 1'b1;
      if (key_valid) begin
        if (key == KEY_0) begin
          level     <= '0;
          sleep_arm <= 1'b0;
        end else if (key == KEY_SLEEP) begin
          sleep_arm <= !sleep_arm;
          sleep_cnt <= '0;
        end else if (int'(key) < LEVELS) begin
          level <= LW'(key);
        end
      end
    end
  end

  always_comb begin
    tgt = (level == LW'(LEVELS - 1)) ? MAX_DUTY : PWM_W'(level) * STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HOLD;
      duty     <= '0;
      ramp_cnt <= '0;
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      ramp_cnt <= ramp_cnt_nxt;
    end
  end

  // Direction is re-checked every cycle so a target change mid-ramp reverses at once.
  always_comb begin
    state_nxt    = state;
    duty_nxt     = duty;
    ramp_cnt_nxt = ramp_cnt;
    case (state)
      HOLD: begin
        ramp_cnt_nxt = '0;
        if (tgt > duty)      state_nxt = UP;
        else if (tgt < duty) state_nxt = DOWN;
      end
      UP: begin
        if (tgt < duty) begin
          state_nxt    = DOWN;
          ramp_cnt_nxt = '0;
        end else if (tgt == duty) begin
          state_nxt    = HOLD;
          ramp_cnt_nxt = '0;
        end else if (ramp_cnt == RAMP_TC) begin
          duty_nxt     = duty + 1'b1;
          ramp_cnt_nxt = '0;
          if (duty_nxt == tgt) state_nxt = HOLD;
        end else begin
          ramp_cnt_nxt = ramp_cnt + 1'b1;
        end
      end
      DOWN: begin
        if (tgt > duty) begin
          state_nxt    = UP;
          ramp_cnt_nxt = '0;
        end else if (tgt == duty) begin
          state_nxt    = HOLD;
          ramp_cnt_nxt = '0;
        end else if (ramp_cnt == RAMP_TC) begin
          duty_nxt     = duty - 1'b1;
          ramp_cnt_nxt = '0;
          if (duty_nxt == tgt) state_nxt = HOLD;
        end else begin
          ramp_cnt_nxt = ramp_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = HOLD;
        ramp_cnt_nxt = '0;
      end
    endcase
  end

  assign ramping = (state != HOLD);

  fan_pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_fan_speed_ramp_ctrl.sv
// Self-checking bench for fan_speed_ramp_ctrl: key-decode table plus ramp/sleep sequences.
module tb_fan_speed_ramp_ctrl;
  import fan_speed_ramp_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, key_valid;
  logic [3:0] key;
  logic [1:0] level;
  logic [7:0] duty;
  logic       pwm_out, ramping, sleep_arm;

  logic       rst2_n, kv2;
  logic [3:0] k2;
  logic [0:0] level2;
  logic [7:0] duty2;
  logic       pwm2, ramping2, arm2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fan_speed_ramp_ctrl #(.LEVELS(4), .PWM_W(8), .RAMP_DIV(4), .SLEEP_CYC(1000)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .level(level),
    .duty(duty), .pwm_out(pwm_out), .ramping(ramping), .sleep_arm(sleep_arm)
  );

  fan_speed_ramp_ctrl #(.LEVELS(2), .PWM_W(8), .RAMP_DIV(4), .SLEEP_CYC(1000)) dut2 (
    .clk(clk), .rst_n(rst2_n), .key(k2), .key_valid(kv2), .level(level2),
    .duty(duty2), .pwm_out(pwm2), .ramping(ramping2), .sleep_arm(arm2)
  );

  typedef struct {
    logic [3:0] key;
    logic       kv;
    logic [1:0] lvl;
    logic       arm;
  } vec_t;

  typedef struct {
    logic [1:0] lvl;
    logic       arm;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    key_valid = 1'b0;
    key       = KEY_0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [3:0] k);
    @(negedge clk);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_duty(input int val, input int bound, output int cycles);
    cycles = 0;
    while (duty != 8'(val) && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int k, hi, mx, mn;
    exp_t e;

    vecs[0]  = '{KEY_1,  1'b1, 2'd1, 1'b0};
    vecs[1]  = '{KEY_2,  1'b0, 2'd1, 1'b0};
    vecs[2]  = '{4'hE,   1'b1, 2'd1, 1'b0};
    vecs[3]  = '{KEY_3,  1'b1, 2'd3, 1'b0};
    vecs[4]  = '{KEY_4,  1'b1, 2'd3, 1'b0};
    vecs[5]  = '{KEY_9,  1'b1, 2'd3, 1'b1};
    vecs[6]  = '{KEY_2,  1'b1, 2'd2, 1'b1};
    vecs[7]  = '{KEY_9,  1'b1, 2'd2, 1'b0};
    vecs[8]  = '{KEY_9,  1'b1, 2'd2, 1'b1};
    vecs[9]  = '{KEY_0,  1'b1, 2'd0, 1'b0};
    vecs[10] = '{KEY_8,  1'b1, 2'd0, 1'b0};
    vecs[11] = '{KEY_2,  1'b1, 2'd2, 1'b0};

    rst_n = 1'b0; key_valid = 1'b0; key = KEY_0;
    rst2_n = 1'b0; kv2 = 1'b0; k2 = KEY_0;
    repeat (2) @(negedge clk);
    check("rst_level", int'(level), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ramping", int'(ramping), 0);
    check("rst_sleep_arm", int'(sleep_arm), 0);
    rst_n = 1'b1; rst2_n = 1'b1;

    // key-decode table through the scoreboard
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("vec%0d_level", i - 1), int'(level), int'(e.lvl));
        check($sformatf("vec%0d_arm", i - 1), int'(sleep_arm), int'(e.arm));
      end
      if (i < 12) begin
        key       = vecs[i].key;
        key_valid = vecs[i].kv;
        sb.push_back('{vecs[i].lvl, vecs[i].arm});
      end else begin
        key_valid = 1'b0;
      end
    end

    // reset mid-ramp
    do_reset();
    strobe(KEY_3);
    wait_duty(40, 400, k);
    check("t1_reach40", int'(duty), 40);
    #2 rst_n = 1'b0;
    #1;
    check("t1_level", int'(level), 0);
    check("t1_duty", int'(duty), 0);
    check("t1_pwm", int'(pwm_out), 0);
    check("t1_ramping", int'(ramping), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ramp OFF -> level 2
    do_reset();
    strobe(KEY_2);
    check("t2_level", int'(level), 2);
    for (k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1) check("t2_ramp_start", int'(ramping), 1);
      if (duty == 8'd170) break;
    end
    check("t2_cycles", k, 681);
    check("t2_ramping_done", int'(ramping), 0);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    check("t2_pwm_high", hi, 170);
    check("t2_duty_hold", int'(duty), 170);

    // reversal mid-ramp
    do_reset();
    strobe(KEY_3);
    wait_duty(100, 800, k);
    check("t3_reach100", int'(duty), 100);
    strobe(KEY_1);
    mx = int'(duty); mn = int'(duty);
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (int'(duty) > mx) mx = int'(duty);
      if (int'(duty) < mn) mn = int'(duty);
      if (!ramping) break;
    end
    check("t3_peak", mx, 100);
    check("t3_min", mn, 85);
    check("t3_final", int'(duty), 85);
    check("t3_ramping", int'(ramping), 0);

    // sleep expiry
    do_reset();
    strobe(KEY_3);
    strobe(KEY_9);
    check("t5_arm", int'(sleep_arm), 1);
    for (k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (!sleep_arm) break;
    end
    check("t5_expiry_cycles", k, 1000);
    check("t5_level", int'(level), 0);
    wait_duty(0, 3000, k);
    @(negedge clk);
    check("t5_duty_off", int'(duty), 0);
    check("t5_ramping_off", int'(ramping), 0);

    strobe(KEY_2);
    strobe(KEY_9);
    check("t5_toggle_on", int'(sleep_arm), 1);
    strobe(KEY_9);
    check("t5_toggle_off", int'(sleep_arm), 0);
    check("t5_toggle_level", int'(level), 2);

    // expiry collides with a level key
    do_reset();
    strobe(KEY_3);
    strobe(KEY_9);
    repeat (999) @(negedge clk);
    key = KEY_2; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("t6_collide_level", int'(level), 0);
    check("t6_collide_arm", int'(sleep_arm), 0);

    // two-level variant
    @(negedge clk);
    k2 = KEY_1; kv2 = 1'b1;
    @(negedge clk);
    kv2 = 1'b0;
    check("t6_l2_level", int'(level2), 1);
    for (k = 1; k <= 1500; k++) begin
      @(negedge clk);
      if (duty2 == 8'd255) break;
    end
    check("t6_l2_cycles", k, 1021);
    check("t6_l2_duty", int'(duty2), 255);
    check("t6_l2_ramping", int'(ramping2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
